// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO with thresholds, synchronous clear and error pulses.
// Define SYNC_FIFO_V2_SHOWAHEAD_EN for first-word-fall-through q; default is registered q.
module sync_fifo_v2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_U  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_U  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_U = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   usedw_q, usedw_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok, mem_we;

    // Flags come straight from the registered count, so requests never reach them combinationally.
    assign empty        = (usedw_q == '0);
    assign full         = (usedw_q == DEPTH_U);
    assign almost_empty = (usedw_q <= AEMPTY_U);
    assign almost_full  = (usedw_q >= AFULL_U);
    assign usedw        = usedw_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ok       = wrreq & ~full;
        rd_ok       = rdreq & ~empty;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        usedw_d     = usedw_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        mem_we      = 1'b0;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            mem_we      = wr_ok & ~rst;
            overflow_d  = wrreq & full;
            underflow_d = rdreq & empty;
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // Count is tracked explicitly; pointer difference is ambiguous at full.
            case ({wr_ok, rd_ok})
                2'b10:   usedw_d = usedw_q + 1'b1;
                2'b01:   usedw_d = usedw_q - 1'b1;
                default: usedw_d = usedw_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data;
        end
    end

`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
    assign q = mem[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (!sclr && rd_ok) begin
            q_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Self-checking bench for sync_fifo_v2 against a queue-based reference model.
// Covers both read modes depending on SYNC_FIFO_V2_SHOWAHEAD_EN.
module tb_sync_fifo_v2;

    logic       clk_in;
    logic       rst, sclr, wrreq, rdreq;
    logic [7:0] data;
    logic [7:0] q;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] usedw;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mq[$];
    logic [7:0] model_q;
    logic       exp_ovf, exp_udf;
    logic       q_valid;
    logic [7:0] q_exp;

    sync_fifo_v2 dut (
        .clk_in(clk_in), .rst(rst), .sclr(sclr), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .usedw(usedw),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one clock and apply the FIFO rules to the reference queue.
    task automatic cycle();
        bit was_full, was_empty;
        @(posedge clk_in);
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (rst) begin
            mq.delete();
            model_q = 8'h00;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else if (sclr) begin
            mq.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            exp_ovf = wrreq && was_full;
            exp_udf = rdreq && was_empty;
            if (rdreq && !was_empty) model_q = mq.pop_front();
            if (wrreq && !was_full) mq.push_back(data);
        end
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
        q_valid = (mq.size() > 0);
        q_exp   = q_valid ? mq[0] : 8'h00;
`else
        q_valid = 1'b1;
        q_exp   = model_q;
`endif
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d);
        wrreq = w;
        rdreq = r;
        data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(0, 0, 0); cycle(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin drive(1, 0, 8'(8'h30 + i)); cycle(); end
        drive(0, 1, 0); cycle();
        rst = 1'b1; drive(1, 1, 8'hEE); cycle(); rst = 1'b0; drive(0, 0, 0);
        compared++; if (usedw !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_usedw: got %0d expected 0", usedw); end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        compared++; if (full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        compared++; if (almost_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_aempty: got %b expected 1", almost_empty); end
        compared++; if (almost_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_afull: got %b expected 0", almost_full); end
        compared++; if ({overflow, underflow} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_err: got %b%b expected 00", overflow, underflow); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
        compared++; if (q !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_q: got %h expected 00", q); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            drive(1, 0, 8'(i)); cycle();
            compared++; if (usedw !== 5'(i)) begin mismatched++; $display("[TB] FAIL fill_usedw: got %0d expected %0d", usedw, i); end
            compared++; if (almost_full !== (i >= 14)) begin mismatched++; $display("[TB] FAIL fill_afull@%0d: got %b expected %b", i, almost_full, i >= 14); end
            compared++; if (full !== (i == 16)) begin mismatched++; $display("[TB] FAIL fill_full@%0d: got %b expected %b", i, full, i == 16); end
            compared++; if (almost_empty !== (i <= 2)) begin mismatched++; $display("[TB] FAIL fill_aempty@%0d: got %b expected %b", i, almost_empty, i <= 2); end
            compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_empty@%0d: got %b expected 0", i, empty); end
        end
        drive(1, 0, 8'h77); cycle();
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_overflow: got %b expected 1", overflow); end
        compared++; if (usedw !== 5'd16) begin mismatched++; $display("[TB] FAIL fill_usedw_ovf: got %0d expected 16", usedw); end
        drive(0, 0, 0); cycle();
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_overflow_pulse: got %b expected 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            drive(0, 1, 0); cycle();
            compared++; if (usedw !== 5'(16 - i)) begin mismatched++; $display("[TB] FAIL drain_usedw: got %0d expected %0d", usedw, 16 - i); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
            compared++; if (q !== 8'(i)) begin mismatched++; $display("[TB] FAIL drain_q: got %h expected %h", q, 8'(i)); end
`else
            if (q_valid) begin
                compared++; if (q !== q_exp) begin mismatched++; $display("[TB] FAIL drain_q_sa: got %h expected %h", q, q_exp); end
            end
`endif
        end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
        drive(0, 1, 0); cycle();
        compared++; if (underflow !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_underflow: got %b expected 1", underflow); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
        compared++; if (q !== 8'h10) begin mismatched++; $display("[TB] FAIL drain_q_hold: got %h expected 10", q); end
`endif
        drive(0, 0, 0); cycle();
        compared++; if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_underflow_pulse: got %b expected 0", underflow); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] q_before;
        for (int i = 0; i < 5; i++) begin drive(1, 0, 8'($urandom)); cycle(); end
        drive(1, 1, 8'($urandom)); cycle();
        compared++; if (usedw !== 5'd5) begin mismatched++; $display("[TB] FAIL simul_mid_usedw: got %0d expected 5", usedw); end
        compared++; if (q_valid && q !== q_exp) begin mismatched++; $display("[TB] FAIL simul_mid_q: got %h expected %h", q, q_exp); end
        for (int i = 0; i < 11; i++) begin drive(1, 0, 8'($urandom)); cycle(); end
        drive(1, 1, 8'($urandom)); cycle();
        compared++; if (usedw !== 5'd15) begin mismatched++; $display("[TB] FAIL simul_full_usedw: got %0d expected 15", usedw); end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL simul_full_overflow: got %b expected 1", overflow); end
        for (int i = 0; i < 15; i++) begin drive(0, 1, 0); cycle(); end
        q_before = q_exp;
        drive(1, 1, 8'hC3); cycle();
        compared++; if (usedw !== 5'd1) begin mismatched++; $display("[TB] FAIL simul_empty_usedw: got %0d expected 1", usedw); end
        compared++; if (underflow !== 1'b1) begin mismatched++; $display("[TB] FAIL simul_empty_underflow: got %b expected 1", underflow); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
        compared++; if (q !== q_before) begin mismatched++; $display("[TB] FAIL simul_empty_q: got %h expected %h", q, q_before); end
`else
        compared++; if (q !== 8'hC3) begin mismatched++; $display("[TB] FAIL simul_empty_q_sa: got %h expected c3", q); end
`endif
        drive(0, 1, 0); cycle();
        drive(0, 0, 0); cycle();
    endtask

    task automatic test_wrap();
        rst = 1'b1; drive(0, 0, 0); cycle(); rst = 1'b0;
        for (int t = 0; t < 45; t++) begin
            drive(t < 40, t >= 5, 8'(t + 1)); cycle();
            if (t >= 5 && t < 40) begin
                compared++; if (usedw !== 5'd5) begin mismatched++; $display("[TB] FAIL wrap_usedw@%0d: got %0d expected 5", t, usedw); end
            end
            if (t < 44) begin
                compared++; if (full !== 1'b0 || empty !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_flags@%0d: got full=%b empty=%b expected 0/0", t, full, empty); end
            end
            compared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_err@%0d: got %b%b expected 00", t, overflow, underflow); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
            if (t >= 5) begin
                compared++; if (q !== 8'(t - 4)) begin mismatched++; $display("[TB] FAIL wrap_q@%0d: got %h expected %h", t, q, 8'(t - 4)); end
            end
`else
            if (q_valid) begin
                compared++; if (q !== q_exp) begin mismatched++; $display("[TB] FAIL wrap_q_sa@%0d: got %h expected %h", t, q, q_exp); end
            end
`endif
        end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_end_empty: got %b expected 1", empty); end
        drive(0, 0, 0);
    endtask

    task automatic test_clear();
        logic [7:0] q_before;
        rst = 1'b1; drive(0, 0, 0); cycle(); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin drive(1, 0, 8'(8'h40 + i)); cycle(); end
        drive(0, 1, 0); cycle();
        q_before = q_exp;
        sclr = 1'b1; drive(1, 0, 8'h99); cycle(); sclr = 1'b0; drive(0, 0, 0);
        compared++; if (usedw !== 5'd0) begin mismatched++; $display("[TB] FAIL sclr_usedw: got %0d expected 0", usedw); end
        compared++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL sclr_empty: got %b%b expected 11", empty, almost_empty); end
        compared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL sclr_err: got %b%b expected 00", overflow, underflow); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
        compared++; if (q !== 8'h40 || q !== q_before) begin mismatched++; $display("[TB] FAIL sclr_q_hold: got %h expected 40", q); end
`endif
        cycle();
        compared++; if (usedw !== 5'd0) begin mismatched++; $display("[TB] FAIL sclr_write_dropped: got %0d expected 0", usedw); end
        for (int i = 0; i < 9; i++) begin drive(1, 0, 8'(8'h50 + i)); cycle(); end
        drive(0, 1, 0); cycle();
        rst = 1'b1; drive(1, 0, 8'h99); cycle(); rst = 1'b0; drive(0, 0, 0);
        compared++; if (usedw !== 5'd0 || empty !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_clear: got usedw=%0d empty=%b expected 0/1", usedw, empty); end
`ifndef SYNC_FIFO_V2_SHOWAHEAD_EN
        compared++; if (q !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_clear_q: got %h expected 00", q); end
`endif
    endtask

    task automatic test_random();
        int wp, rp;
        for (int i = 0; i < 600; i++) begin
            wp = ((i / 100) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            rst  = ($urandom_range(0, 249) == 0);
            sclr = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
            cycle();
            compared++; if (usedw !== 5'(mq.size())) begin mismatched++; $display("[TB] FAIL rand_usedw@%0d: got %0d expected %0d", i, usedw, mq.size()); end
            compared++; if ({empty, full} !== {mq.size() == 0, mq.size() == 16}) begin mismatched++; $display("[TB] FAIL rand_ef@%0d: got %b%b size %0d", i, empty, full, mq.size()); end
            compared++; if ({almost_empty, almost_full} !== {mq.size() <= 2, mq.size() >= 14}) begin mismatched++; $display("[TB] FAIL rand_almost@%0d: got %b%b size %0d", i, almost_empty, almost_full, mq.size()); end
            compared++; if ({overflow, underflow} !== {exp_ovf, exp_udf}) begin mismatched++; $display("[TB] FAIL rand_err@%0d: got %b%b expected %b%b", i, overflow, underflow, exp_ovf, exp_udf); end
            if (q_valid) begin
                compared++; if (q !== q_exp) begin mismatched++; $display("[TB] FAIL rand_q@%0d: got %h expected %h", i, q, q_exp); end
            end
        end
        rst = 1'b0; sclr = 1'b0; drive(0, 0, 0);
    endtask

`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
    task automatic test_showahead();
        rst = 1'b1; drive(0, 0, 0); cycle(); rst = 1'b0;
        drive(1, 0, 8'hA5); cycle(); drive(0, 0, 0);
        compared++; if (empty !== 1'b0) begin mismatched++; $display("[TB] FAIL sa_empty: got %b expected 0", empty); end
        compared++; if (q !== 8'hA5) begin mismatched++; $display("[TB] FAIL sa_first_q: got %h expected a5", q); end
        drive(1, 1, 8'h5A); cycle(); drive(0, 0, 0);
        compared++; if (q !== 8'h5A) begin mismatched++; $display("[TB] FAIL sa_next_q: got %h expected 5a", q); end
        compared++; if (usedw !== 5'd1) begin mismatched++; $display("[TB] FAIL sa_usedw: got %0d expected 1", usedw); end
    endtask
`endif

    initial begin
        rst = 1'b1; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = 8'h00;
        model_q = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0; q_valid = 1'b0; q_exp = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_clear();
        test_random();
`ifdef SYNC_FIFO_V2_SHOWAHEAD_EN
        test_showahead();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
